midi_voice_alloc: RTL
=====================

Name: midi_voice_alloc

Overview:
Parametrised successor to the single-voice MIDI parser. It consumes the byte stream from the MIDI UART receiver, one byte per strobe. It decodes channel messages with running status and allocates Note On/Off events across NUM_VOICES polyphonic voice slots. Per-voice note, velocity and gate outputs drive the downstream per-voice oscillator/envelope blocks.

Parameters:
NUM_VOICES, 4, number of voice slots (1..16).
CHANNEL, 0, MIDI channel accepted, 0..15.
OMNI, 0, 1 = accept all channels and ignore CHANNEL.

Ports:
CLK_50MHZ  in  1  system clock.
RST_N  in  1  asynchronous active-low reset.
BYTE_IN  in  8  received MIDI byte; valid only while BYTE_READY is high.
BYTE_READY  in  1  one-cycle strobe per received byte.
VOICE_NOTE  out  7*NUM_VOICES  note number per voice; voice i occupies bits [7i+6:7i].
VOICE_VEL  out  7*NUM_VOICES  velocity per voice, same packing.
VOICE_GATE  out  NUM_VOICES  1 = voice held.
EVENT  out  1  one-cycle pulse whenever any voice output changes.
STEAL  out  1  one-cycle pulse coincident with EVENT when an allocation steals a voice.

Behaviour:
- Reset (async, RST_N=0):
  - All VOICE_NOTE, VOICE_VEL, VOICE_GATE = 0; EVENT = STEAL = 0.
  - Parser state IDLE; running status cleared; steal pointer = 0.
  - Reset mid-message discards the partial message.
- Bytes are processed only on cycles with BYTE_READY=1. All other cycles hold state.
- Byte classes:
  - 0xF8–0xFF (real-time): ignored entirely; parser state and running status unchanged.
  - 0xF0–0xF7 (system common/SysEx): clear running status; state IDLE. Data bytes then ignored until the next channel status.
  - 0x80–0xEF (channel status): latch status. If the channel mismatches (and OMNI=0) or the type is not 0x8n/0x9n/0xBn, enter SKIP. Otherwise enter D1.
    - Data length: 2 bytes for 0x8n/0x9n/0xAn/0xBn/0xEn; 1 byte for 0xCn/0xDn.
    - A status byte arriving mid-message aborts that message and restarts on the new status.
  - 0x00–0x7F (data):
    - IDLE: ignored.
    - D1: latch byte as d1. Go to D2, or complete the message if length is 1.
    - D2: complete the message using d1 and this byte.
    - SKIP: count data bytes of the latched length.
- States: IDLE, D1, D2, SKIP. After completion or skip, return to D1 (SKIP returns to its own start) with the same status (running status).
- Message actions, applied on the completing byte:
  - Note On (0x9n, vel>0), with note=d1 and vel=d2, first matching rule applies:
    1. A voice with GATE=1 and NOTE=note exists: retrigger the lowest such index by updating VEL.
    2. Otherwise, the lowest-index voice with GATE=0 takes NOTE, VEL and GATE=1.
    3. Otherwise, steal the voice at the steal pointer: load NOTE, VEL, GATE=1; pulse STEAL. The pointer advances (wraps NUM_VOICES-1 → 0).
    - The steal pointer changes only on a steal.
  - Note Off (0x8n any vel, or 0x9n vel=0): clear GATE of every voice with GATE=1 and NOTE=d1. NOTE/VEL are retained for the release phase. No matching voice → no change, no EVENT.
  - Control Change 0xBn with d1=123 or d1=120: clear all GATEs. Other CC numbers are ignored.
- Latency: voice outputs and EVENT/STEAL are registered. They update on the clock edge after the cycle carrying the completing BYTE_READY (1-cycle latency). EVENT is high for exactly one cycle.
- Back-to-back strobes on consecutive cycles are supported at full rate; each byte sees the result of the previous byte.
- Voice outputs are fully registered; no combinational path from BYTE_IN to outputs.

Test Plan:
- Reset then 0x90,0x3C,0x64 → cycle after the third strobe: voice0 NOTE=60, VEL=100, GATE=1; EVENT=1 for one cycle; other voices 0.
- Running status: 0x90,0x3C,0x64,0x40,0x50,0x43,0x00 → voice0=60 held, voice1=64 vel 80; then 0x43 vel 0 produces no change (not held). 0x3C,0x00 → voice0 GATE=0 with NOTE=60 retained.
- NUM_VOICES=4: five Note Ons 60,62,64,65,67 → voices 0–3 = 60,62,64,65. Fifth: voice0=67, STEAL=1, pointer=1. A sixth note 69 → voice1=69.
- Channel filter (CHANNEL=0, OMNI=0): 0x91,0x3C,0x64 → no EVENT. Following 0x3C,0x64 (running 0x91) is also ignored. Same with OMNI=1 → voice0=60.
- Interleaving: 0x90, 0xF8, 0x3C, 0xFE, 0x64 → note accepted. 0x90, 0x3C, 0xF0, 0x64 → no note; subsequent data ignored until a new status.
- All notes off: three held voices, then 0xB0,0x7B,0x00 → all GATE=0 in one cycle, single EVENT pulse. Assert RST_N low between 0x90 and 0x3C → outputs 0 immediately; post-reset 0x3C,0x64 ignored.

Source files
------------

// File: rtl/midi_voice_alloc.sv
// midi_voice_alloc: MIDI channel-message parser with running status and
// polyphonic Note On/Off voice allocation across NUM_VOICES slots.
module midi_voice_alloc #(
    parameter int unsigned NUM_VOICES = 4,
    parameter int unsigned CHANNEL    = 0,
    parameter int unsigned OMNI       = 0
) (
    input  logic                      clk_50mhz,
    input  logic                      rst_n,
    input  logic [7:0]                byte_in,
    input  logic                      byte_ready,
    output logic [7*NUM_VOICES-1:0]   voice_note,
    output logic [7*NUM_VOICES-1:0]   voice_vel,
    output logic [NUM_VOICES-1:0]     voice_gate,
    output logic                      event_pulse,
    output logic                      steal
);

    localparam int unsigned DATA_W = 7;
    localparam int unsigned PTR_W  = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;

    // Message type is status[6:4]: 0x8n=000, 0x9n=001, 0xBn=011, 0xCn=100, 0xDn=101
    localparam logic [2:0] TYPE_OFF = 3'b000;
    localparam logic [2:0] TYPE_ON  = 3'b001;
    localparam logic [2:0] TYPE_CC  = 3'b011;
    localparam logic [2:0] TYPE_PC  = 3'b100;
    localparam logic [2:0] TYPE_AT  = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_D1,
        ST_D2,
        ST_SKIP
    } state_t;

    state_t                 state, state_nx;
    logic [2:0]             msg_type, msg_type_nx;
    logic [DATA_W-1:0]      d1, d1_nx;
    logic                   skip_cnt, skip_cnt_nx;

    logic [NUM_VOICES-1:0][DATA_W-1:0] note_q, note_nx;
    logic [NUM_VOICES-1:0][DATA_W-1:0] vel_q, vel_nx;
    logic [NUM_VOICES-1:0]             gate_q, gate_nx;
    logic [PTR_W-1:0]                  steal_ptr, steal_ptr_nx;
    logic                              event_nx, steal_nx;

    logic              is_rt, is_sys, is_chan, is_data;
    logic              chan_ok, type_ok, len_one, complete;
    logic [DATA_W-1:0] d2;
    logic              hit_found, free_found;
    logic [PTR_W-1:0]  hit_idx, free_idx;

    // Byte classification and status filtering
    always_comb begin
        is_rt    = byte_ready && (byte_in[7:3] == 5'b11111);
        is_sys   = byte_ready && (byte_in[7:3] == 5'b11110);
        is_chan  = byte_ready && byte_in[7] && (byte_in[7:4] != 4'hF);
        is_data  = byte_ready && !byte_in[7];
        chan_ok  = (OMNI != 0) || (byte_in[3:0] == 4'(CHANNEL));
        type_ok  = (byte_in[6:4] == TYPE_OFF) || (byte_in[6:4] == TYPE_ON) ||
                   (byte_in[6:4] == TYPE_CC);
        len_one  = (msg_type == TYPE_PC) || (msg_type == TYPE_AT);
        complete = is_data && (state == ST_D2);
        d2       = byte_in[6:0];
    end

    // Parser state register
    always_ff @(posedge clk_50mhz or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            msg_type <= 3'b000;
            d1       <= '0;
            skip_cnt <= 1'b0;
        end else begin
            state    <= state_nx;
            msg_type <= msg_type_nx;
            d1       <= d1_nx;
            skip_cnt <= skip_cnt_nx;
        end
    end

    // Parser next state; a new status always restarts, real-time bytes fall through untouched
    always_comb begin
        state_nx    = state;
        msg_type_nx = msg_type;
        d1_nx       = d1;
        skip_cnt_nx = skip_cnt;
        if (is_sys) begin
            state_nx = ST_IDLE;
        end else if (is_chan) begin
            msg_type_nx = byte_in[6:4];
            skip_cnt_nx = 1'b0;
            state_nx    = (chan_ok && type_ok) ? ST_D1 : ST_SKIP;
        end else if (is_data) begin
            case (state)
                // Accepted types are all two-byte messages
                ST_D1: begin
                    d1_nx    = byte_in[6:0];
                    state_nx = ST_D2;
                end
                ST_D2:   state_nx = ST_D1;
                ST_SKIP: skip_cnt_nx = (len_one || skip_cnt) ? 1'b0 : 1'b1;
                default: state_nx = state;
            endcase
        end
    end

    // Lowest-index held voice on the note, and lowest-index free voice
    always_comb begin
        hit_found  = 1'b0;
        hit_idx    = '0;
        free_found = 1'b0;
        free_idx   = '0;
        for (int i = NUM_VOICES - 1; i >= 0; i--) begin
            if (gate_q[i] && (note_q[i] == d1)) begin
                hit_found = 1'b1;
                hit_idx   = PTR_W'(i);
            end
            if (!gate_q[i]) begin
                free_found = 1'b1;
                free_idx   = PTR_W'(i);
            end
        end
    end

    // Voice update applied on the completing data byte
    always_comb begin
        note_nx      = note_q;
        vel_nx       = vel_q;
        gate_nx      = gate_q;
        steal_ptr_nx = steal_ptr;
        steal_nx     = 1'b0;
        if (complete) begin
            if ((msg_type == TYPE_ON) && (d2 != '0)) begin
                if (hit_found) begin
                    vel_nx[hit_idx] = d2;
                end else if (free_found) begin
                    note_nx[free_idx] = d1;
                    vel_nx[free_idx]  = d2;
                    gate_nx[free_idx] = 1'b1;
                end else begin
                    note_nx[steal_ptr] = d1;
                    vel_nx[steal_ptr]  = d2;
                    gate_nx[steal_ptr] = 1'b1;
                    steal_nx           = 1'b1;
                    steal_ptr_nx       = (steal_ptr == PTR_W'(NUM_VOICES - 1)) ?
                                         '0 : steal_ptr + PTR_W'(1);
                end
            end else if ((msg_type == TYPE_OFF) || (msg_type == TYPE_ON)) begin
                for (int i = 0; i < NUM_VOICES; i++) begin
                    if (gate_q[i] && (note_q[i] == d1)) begin
                        gate_nx[i] = 1'b0;
                    end
                end
            end else if ((msg_type == TYPE_CC) && ((d1 == 7'd123) || (d1 == 7'd120))) begin
                gate_nx = '0;
            end
        end
        event_nx = (note_nx != note_q) || (vel_nx != vel_q) || (gate_nx != gate_q);
    end

    // Voice, pointer and pulse registers
    always_ff @(posedge clk_50mhz or negedge rst_n) begin
        if (!rst_n) begin
            note_q      <= '0;
            vel_q       <= '0;
            gate_q      <= '0;
            steal_ptr   <= '0;
            event_pulse <= 1'b0;
            steal       <= 1'b0;
        end else begin
            note_q      <= note_nx;
            vel_q       <= vel_nx;
            gate_q      <= gate_nx;
            steal_ptr   <= steal_ptr_nx;
            event_pulse <= event_nx;
            steal       <= steal_nx;
        end
    end

    assign voice_note = note_q;
    assign voice_vel  = vel_q;
    assign voice_gate = gate_q;

endmodule
